tx_memory: RTL and testbench
============================

TX_MEMORY -- requirements
Module: tx_memory

Interface
REQ-001 SHALL have parameter g_pages, default 16: number of 32-bit pages carried per frame, range 1..64.
REQ-002 SHALL have parameter g_sync, default 16'h5A3C: frame sync word.
REQ-003 SHALL have port ClkRs_ix, input, ckrs_t, carrying the single clock .clk and the asynchronous active-high reset .reset.
REQ-004 SHALL have port wr_addr_ib, input, $clog2(g_pages) bits (minimum 1): shadow page write address.
REQ-005 SHALL have port wr_data_ib32, input, 32 bits: shadow page write data.
REQ-006 SHALL have port wr_en_i, input, 1 bit: shadow write strobe.
REQ-007 SHALL have port commit_i, input, 1 bit: request to copy shadow to active at the next frame start.
REQ-008 SHALL have port enable_i, input, 1 bit: enables frame streaming.
REQ-009 SHALL have port data_ob16, output, 16 bits: stream word, registered.
REQ-010 SHALL have port frame_start_o, output, 1 bit: high while data_ob16 carries the sync word.
REQ-011 SHALL have port commit_ack_o, output, 1 bit: one-cycle pulse when a commit is applied.
REQ-012 SHALL have port busy_o, output, 1 bit: high while a frame is in progress (any state other than IDLE).

Function
REQ-013 SHALL hold two g_pages x 32 arrays: shadow (written by the user) and active (transmitted).
REQ-014 SHALL write wr_data_ib32 into shadow[wr_addr_ib] on each clock with wr_en_i=1; wr_addr_ib >= g_pages SHALL be ignored.
REQ-015 SHALL implement the states IDLE, SYNC, DATA and CSUM; every output SHALL be registered and change only on the rising edge.
REQ-016 Frame format SHALL be: g_sync, then for p = 0..g_pages-1 active[p][31:16] followed by active[p][15:0], then the checksum. Frame length is 2*g_pages+2 words.
REQ-017 The checksum SHALL be the bitwise XOR of all 2*g_pages data half-words of that frame.
REQ-018 In IDLE, data_ob16 SHALL be 16'h0000. If enable_i=1 at an edge in IDLE, the next cycle SHALL output g_sync (SYNC state) with frame_start_o=1.
REQ-019 SYNC SHALL always advance to DATA. DATA SHALL last exactly 2*g_pages cycles and then advance to CSUM.
REQ-020 From CSUM: if enable_i=1, the next cycle SHALL be SYNC, giving back-to-back frames with no idle gap; otherwise the next state SHALL be IDLE.
REQ-021 Deasserting enable_i mid-frame SHALL NOT truncate the frame; the frame completes, including its checksum.
REQ-022 Any commit_i=1 SHALL set a pending flag. Repeated requests before the flag is applied SHALL merge into a single commit.
REQ-023 On each transition into SYNC with the flag pending, the block SHALL copy active <= shadow, clear the flag and pulse commit_ack_o in the SYNC cycle. The frame that starts in that SYNC cycle SHALL carry the new image.
REQ-024 A write (wr_en_i=1) in the same cycle as the copy SHALL be included in the copied image.
REQ-025 A commit_i arriving in the same cycle as the copy SHALL be consumed by that copy (no second ack).
REQ-026 Active contents SHALL never change during DATA or CSUM, so every frame is self-consistent.
REQ-027 With commit pending and enable_i=0, the block SHALL remain in IDLE without committing until the next frame starts.

Reset
REQ-028 While ClkRs_ix.reset=1, asynchronously: state=IDLE, data_ob16=16'h0000, frame_start_o=0, commit_ack_o=0, busy_o=0, pending flag cleared, shadow and active arrays cleared to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately. After reset release, streaming SHALL resume only via REQ-018.

Verification
REQ-030 The bench SHALL cover, with g_pages=2: after reset, enable=1 with no commit -> words 5A3C,0000,0000,0000,0000,0000 repeating; frame_start_o high on every 6th word.
REQ-031 The bench SHALL cover: write page0=12345678 and page1=9ABCDEF0, commit, enable -> 5A3C,1234,5678,9ABC,DEF0,CSUM=1234^5678^9ABC^DEF0=0x0000; commit_ack_o pulses together with that 5A3C.
REQ-032 The bench SHALL cover: during DATA of frame N, write page0=FFFF0000 and commit -> frame N unchanged; frame N+1 carries FFFF,0000; exactly one ack.
REQ-033 The bench SHALL cover: enable dropped in the 2nd DATA cycle -> frame completes through CSUM, then 0000 and busy_o=0; re-enable -> SYNC on the next cycle.
REQ-034 The bench SHALL cover: write page1=0000AAAA in the same cycle the pending copy occurs -> AAAA appears in the frame starting at that SYNC.
REQ-035 The bench SHALL cover: reset pulsed during DATA -> data_ob16=0000 immediately; after release with enable=1 -> frame of all-zero data with checksum 0000.

Source files
------------

// File: rtl/tx_memory.sv
// tx_memory: double-buffered page memory streamed as framed 16-bit words.
// Frame = sync word, hi/lo half-words of every active page, XOR checksum.
package tx_memory_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module tx_memory
  import tx_memory_pkg::*;
#(
  parameter int          g_pages = 16,
  parameter logic [15:0] g_sync  = 16'h5A3C,
  localparam int         AW      = (g_pages > 1) ? $clog2(g_pages) : 1
) (
  input  ckrs_t          ClkRs_ix,
  input  logic [AW-1:0]  wr_addr_ib,
  input  logic [31:0]    wr_data_ib32,
  input  logic           wr_en_i,
  input  logic           commit_i,
  input  logic           enable_i,
  output logic [15:0]    data_ob16,
  output logic           frame_start_o,
  output logic           commit_ack_o,
  output logic           busy_o
);

  localparam int NW = 2 * g_pages;      // data half-words per frame
  localparam int IW = $clog2(NW);       // NW >= 2, so IW >= 1

  typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

  logic          clk_s;
  logic          rst_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nxt_s;
  logic [AW-1:0] page_nxt_s;
  logic [15:0]   word_nxt_s;
  logic [31:0]   shadow_r [g_pages];
  logic [31:0]   active_r [g_pages];
  logic          pending_r;
  logic          copy_s;
  logic          wr_ok_s;
  logic [15:0]   csum_r;
  logic [15:0]   data_r;
  logic          frame_start_r;
  logic          commit_ack_r;
  logic          busy_r;

  assign clk_s = ClkRs_ix.clk;
  assign rst_s = ClkRs_ix.reset;

  assign data_ob16     = data_r;
  assign frame_start_o = frame_start_r;
  assign commit_ack_o  = commit_ack_r;
  assign busy_o        = busy_r;

  // Next-state and next half-word index of the frame sequencer
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (enable_i) state_nxt_s = SYNC;
        else          state_nxt_s = IDLE;
      end
      SYNC: begin
        state_nxt_s = DATA;
        idx_nxt_s   = {IW{1'b0}};
      end
      DATA: begin
        if (idx_r == IW'(NW - 1)) begin
          state_nxt_s = CSUM;
        end else begin
          state_nxt_s = DATA;
          idx_nxt_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
        end
      end
      CSUM: begin
        if (enable_i) state_nxt_s = SYNC;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Half-word to be shown next, write qualification and commit decision;
  // a commit request in the copy cycle itself is absorbed by that copy
  always_comb begin
    page_nxt_s = AW'(idx_nxt_s >> 1);
    if (idx_nxt_s[0]) word_nxt_s = active_r[page_nxt_s][15:0];
    else              word_nxt_s = active_r[page_nxt_s][31:16];
    wr_ok_s = wr_en_i && (int'(wr_addr_ib) < g_pages);
    copy_s  = (state_nxt_s == SYNC) && (pending_r || commit_i);
  end

  // Shadow image written by the user
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      for (int p = 0; p < g_pages; p++) shadow_r[p] <= 32'h0000_0000;
    end else if (wr_ok_s) begin
      shadow_r[wr_addr_ib] <= wr_data_ib32;
    end
  end

  // Active image, refreshed only when a frame starts so each frame is consistent;
  // a write landing in the copy cycle is forwarded into the copied image
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      for (int p = 0; p < g_pages; p++) active_r[p] <= 32'h0000_0000;
    end else if (copy_s) begin
      for (int p = 0; p < g_pages; p++) begin
        if (wr_ok_s && (wr_addr_ib == AW'(p))) active_r[p] <= wr_data_ib32;
        else                                   active_r[p] <= shadow_r[p];
      end
    end
  end

  // Sequencer state, commit bookkeeping and registered stream outputs
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      state_r       <= IDLE;
      idx_r         <= {IW{1'b0}};
      pending_r     <= 1'b0;
      csum_r        <= 16'h0000;
      data_r        <= 16'h0000;
      frame_start_r <= 1'b0;
      commit_ack_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      commit_ack_r  <= copy_s;
      frame_start_r <= (state_nxt_s == SYNC);
      busy_r        <= (state_nxt_s != IDLE);
      if (copy_s)        pending_r <= 1'b0;
      else if (commit_i) pending_r <= 1'b1;
      case (state_nxt_s)
        SYNC: data_r <= g_sync;
        DATA: begin
          data_r <= word_nxt_s;
          if (state_r == SYNC) csum_r <= word_nxt_s;
          else                 csum_r <= csum_r ^ word_nxt_s;
        end
        CSUM:    data_r <= csum_r;
        default: data_r <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_memory.sv
// Self-checking bench for tx_memory (g_pages = 2): directed scenarios with
// literal expectations plus randomized traffic against a frame-queue model.
module tb_tx_memory;
  import tx_memory_pkg::*;

  localparam int          G      = 2;
  localparam logic [15:0] SYNC_W = 16'h5A3C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  ckrs_t       clk_rs;
  logic [0:0]  wr_addr = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        wr_en   = 1'b0;
  logic        commit  = 1'b0;
  logic        enable  = 1'b0;
  logic [15:0] data_ob16;
  logic        frame_start_o;
  logic        commit_ack_o;
  logic        busy_o;

  assign clk_rs = '{clk: clk, reset: rst};

  tx_memory #(.g_pages(G), .g_sync(SYNC_W)) dut (
    .ClkRs_ix      (clk_rs),
    .wr_addr_ib    (wr_addr),
    .wr_data_ib32  (wr_data),
    .wr_en_i       (wr_en),
    .commit_i      (commit),
    .enable_i      (enable),
    .data_ob16     (data_ob16),
    .frame_start_o (frame_start_o),
    .commit_ack_o  (commit_ack_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;

  // Reference model: shadow/active images and a queue of the words still to send
  logic [31:0] m_shadow [G];
  logic [31:0] m_active [G];
  bit          m_pend;
  logic [15:0] m_q [$];
  logic [15:0] m_data;
  bit          m_fs;
  bit          m_ack;
  bit          m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < G; p++) begin
      m_shadow[p] = 32'h0;
      m_active[p] = 32'h0;
    end
    m_pend = 1'b0;
    m_q.delete();
    m_data = 16'h0;
    m_fs = 1'b0;
    m_ack = 1'b0;
    m_busy = 1'b0;
  endtask

  // One clock edge of the model, using the inputs the DUT samples at that edge
  task automatic model_step();
    logic [15:0] cs;
    m_ack = 1'b0;
    m_fs  = 1'b0;
    if (wr_en && int'(wr_addr) < G) m_shadow[wr_addr] = wr_data;
    if (m_q.size() == 0 && enable) begin
      if (m_pend || commit) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
        m_ack    = 1'b1;
      end
      m_q.push_back(SYNC_W);
      cs = 16'h0;
      for (int p = 0; p < G; p++) begin
        m_q.push_back(m_active[p][31:16]);
        m_q.push_back(m_active[p][15:0]);
        cs = cs ^ m_active[p][31:16] ^ m_active[p][15:0];
      end
      m_q.push_back(cs);
      m_fs = 1'b1;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    if (m_q.size() > 0) begin
      m_data = m_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_data = 16'h0;
      m_busy = 1'b0;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_data"},  data_ob16,     m_data);
    chk({tag, "_fs"},    frame_start_o, m_fs);
    chk({tag, "_ack"},   commit_ack_o,  m_ack);
    chk({tag, "_busy"},  busy_o,        m_busy);
  endtask

  // Inputs are set just after a falling edge; outputs checked on the next falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (commit_ack_o) ack_cnt++;
    cmp_model("cyc");
  endtask

  task automatic expw(input string name, input logic [15:0] w, input logic fs);
    chk({name, "_word"}, data_ob16, w);
    chk({name, "_fs"}, frame_start_o, fs);
  endtask

  // Asynchronous reset pulse, entered and left around falling edges
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    cmp_model("rst");
    chk("rst_data_lit", data_ob16, 16'h0000);
    chk("rst_busy_lit", busy_o, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a0;
    @(negedge clk);
    do_reset();
    chk("reset_fs", frame_start_o, 1'b0);
    chk("reset_ack", commit_ack_o, 1'b0);

    // Enabled with no commit: all-zero frames back to back
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      expw("zero_frame", (i % 6 == 0) ? SYNC_W : 16'h0000, (i % 6 == 0));
    end
    enable = 1'b0;
    cycle();
    expw("idle_after", 16'h0000, 1'b0);
    chk("idle_busy", busy_o, 1'b0);

    // Write two pages and commit while idle; commit waits for the frame start
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = 32'h12345678; cycle();
    wr_addr = 1'b1; wr_data = 32'h9ABCDEF0; cycle();
    wr_en = 1'b0; commit = 1'b1; cycle();
    commit = 1'b0; cycle();
    chk("pend_idle_ack", commit_ack_o, 1'b0);
    chk("pend_idle_busy", busy_o, 1'b0);
    enable = 1'b1; cycle();
    expw("c1_sync", SYNC_W, 1'b1);
    chk("c1_ack", commit_ack_o, 1'b1);
    cycle(); expw("c1_w0", 16'h1234, 1'b0);
    cycle(); expw("c1_w1", 16'h5678, 1'b0);
    cycle(); expw("c1_w2", 16'h9ABC, 1'b0);
    cycle(); expw("c1_w3", 16'hDEF0, 1'b0);
    cycle(); expw("c1_cs", 16'h0000, 1'b0);

    // Commit during DATA of frame N lands in frame N+1 only
    a0 = ack_cnt;
    cycle(); expw("n_sync", SYNC_W, 1'b1);
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = 32'hFFFF0000; commit = 1'b1;
    cycle(); expw("n_w0", 16'h1234, 1'b0);
    wr_en = 1'b0; commit = 1'b0;
    cycle(); expw("n_w1", 16'h5678, 1'b0);
    cycle(); expw("n_w2", 16'h9ABC, 1'b0);
    cycle(); expw("n_w3", 16'hDEF0, 1'b0);
    cycle(); expw("n_cs", 16'h0000, 1'b0);
    cycle(); expw("n1_sync", SYNC_W, 1'b1);
    chk("n1_ack", commit_ack_o, 1'b1);
    cycle(); expw("n1_w0", 16'hFFFF, 1'b0);
    cycle(); expw("n1_w1", 16'h0000, 1'b0);
    cycle(); expw("n1_w2", 16'h9ABC, 1'b0);
    cycle(); expw("n1_w3", 16'hDEF0, 1'b0);
    cycle(); expw("n1_cs", 16'hBBB3, 1'b0);
    chk("one_ack", ack_cnt - a0, 1);

    // Enable dropped in the second DATA cycle: frame still completes
    cycle(); expw("drop_sync", SYNC_W, 1'b1);
    cycle(); expw("drop_w0", 16'hFFFF, 1'b0);
    enable = 1'b0;
    cycle(); expw("drop_w1", 16'h0000, 1'b0);
    cycle(); expw("drop_w2", 16'h9ABC, 1'b0);
    cycle(); expw("drop_w3", 16'hDEF0, 1'b0);
    cycle(); expw("drop_cs", 16'hBBB3, 1'b0);
    chk("drop_cs_busy", busy_o, 1'b1);
    cycle(); expw("drop_idle", 16'h0000, 1'b0);
    chk("drop_idle_busy", busy_o, 1'b0);
    enable = 1'b1;
    cycle(); expw("reen_sync", SYNC_W, 1'b1);

    // Write coinciding with the copy is part of the new image
    cycle(); expw("wc_w0", 16'hFFFF, 1'b0);
    cycle(); expw("wc_w1", 16'h0000, 1'b0);
    commit = 1'b1;
    cycle(); expw("wc_w2", 16'h9ABC, 1'b0);
    commit = 1'b0;
    cycle(); expw("wc_w3", 16'hDEF0, 1'b0);
    cycle(); expw("wc_cs", 16'hBBB3, 1'b0);
    wr_en = 1'b1; wr_addr = 1'b1; wr_data = 32'h0000AAAA;
    cycle(); expw("wc_sync", SYNC_W, 1'b1);
    chk("wc_ack", commit_ack_o, 1'b1);
    wr_en = 1'b0;
    cycle(); expw("wc2_w0", 16'hFFFF, 1'b0);
    cycle(); expw("wc2_w1", 16'h0000, 1'b0);
    cycle(); expw("wc2_w2", 16'h0000, 1'b0);
    cycle(); expw("wc2_w3", 16'hAAAA, 1'b0);
    cycle(); expw("wc2_cs", 16'h5555, 1'b0);

    // Reset in the middle of DATA aborts the frame and clears the images
    cycle(); expw("pre_rst_sync", SYNC_W, 1'b1);
    cycle(); expw("pre_rst_w0", 16'hFFFF, 1'b0);
    do_reset();
    cycle(); expw("post_rst_sync", SYNC_W, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      expw("post_rst_zero", 16'h0000, 1'b0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 1'($urandom_range(0, 1));
      wr_data = $urandom;
      commit  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
